spi_slave_fsm: RTL and testbench

- Serial front end of the SPI slave interface. It sits directly upstream of the single-port RAM, which it feeds with parallel frames, and downstream of that RAM for read data, which it returns to the master.
- Deserialises 10-bit MOSI frames, MSB first, into rx_data and pulses rx_valid.
- After a read-data command, waits for tx_valid and serialises the RAM's 8-bit word onto MISO.
- SPI bit clock is clk. All sampling and driving happens on rising clk.

---
 rtl/spi_slave_fsm.sv | 121 ++++++++++++
 tb/tb_spi_slave_fsm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_fsm.sv
// SPI slave serial front end: deserialises 10-bit command frames for the RAM
// and shifts the RAM read word back out on MISO after a read-data command.
module spi_slave_fsm #(
  parameter int unsigned DATA_WIDH  = 8,
  parameter int unsigned FRAME_WIDH = DATA_WIDH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [FRAME_WIDH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDH-1:0]  tx_data,
  input  logic                  tx_valid
);

  localparam int unsigned CNT_W = $clog2(FRAME_WIDH + 1);
  localparam int unsigned TXC_W = $clog2(DATA_WIDH + 2);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_WIDH-1:0] frame_q, frame_d;
  logic [FRAME_WIDH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rd_addr_flag_q, rd_addr_flag_d;
  logic [DATA_WIDH-1:0]  tx_shift_q, tx_shift_d;
  logic [TXC_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic                  miso_q, miso_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      frame_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_flag_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frame_q        <= frame_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      miso_q         <= miso_d;
    end
  end

  // tx_cnt_q: 0 = waiting for tx_valid, 1..DATA_WIDH = shifting, DATA_WIDH+1 = done
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    frame_d        = frame_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    miso_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        tx_cnt_d = '0;
        if (!SS_n) state_d = CHK_CMD;
      end
      default: begin
        if (SS_n) begin
          state_d  = IDLE;
          cnt_d    = '0;
          tx_cnt_d = '0;
        end else if (state_q == CHK_CMD) begin
          frame_d = FRAME_WIDH'(MOSI);
          cnt_d   = CNT_W'(1);
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_flag_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end else if (cnt_q != CNT_W'(FRAME_WIDH)) begin
          frame_d = {frame_q[FRAME_WIDH-2:0], MOSI};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_WIDH - 1)) begin
            rx_data_d  = {frame_q[FRAME_WIDH-2:0], MOSI};
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD)  rd_addr_flag_d = 1'b1;
            if (state_q == READ_DATA) rd_addr_flag_d = 1'b0;
          end
        end else if (state_q == READ_DATA) begin
          if (tx_cnt_q == '0) begin
            if (tx_valid) begin
              tx_shift_d = tx_data;
              tx_cnt_d   = TXC_W'(1);
            end
          end else if (tx_cnt_q <= TXC_W'(DATA_WIDH)) begin
            miso_d     = tx_shift_q[DATA_WIDH-1];
            tx_shift_d = {tx_shift_q[DATA_WIDH-2:0], 1'b0};
            tx_cnt_d   = tx_cnt_q + TXC_W'(1);
          end
        end
      end
    endcase
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: expected frames go into a scoreboard queue
// that a negedge monitor drains on every rx_valid; MISO is checked per cycle.
module tb_spi_slave_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0] exp_rx[$];
  logic       miso_zero = 1'b1;
  logic       prev_rx_valid = 1'b0;

  spi_slave_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on every rx_valid, check pulse width and idle MISO.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          chk("rx_valid_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
        chk("rx_valid_width", 32'(prev_rx_valid), 32'd0);
      end
      if (miso_zero) chk("miso_idle", 32'(MISO), 32'd0);
      prev_rx_valid <= rx_valid;
    end else begin
      prev_rx_valid <= 1'b0;
    end
  end

  // Drives SS_n low and the first nbits of frame f; leaves SS_n low.
  task automatic send_bits(input logic [9:0] f, input int nbits, input logic expect_rx);
    SS_n = 1'b0;
    step();
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[9-i];
      if (i == 9 && expect_rx) exp_rx.push_back(f);
      step();
    end
    MOSI = 1'b0;
  endtask

  task automatic end_txn();
    SS_n = 1'b1;
    step();
    step();
  endtask

  task automatic check_shift(input string name, input logic [7:0] w);
    logic [7:0] word;
    word = w;
    miso_zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk(name, 32'(MISO), 32'(word[7-i]));
    end
    step();
    chk({name, "_tail"}, 32'(MISO), 32'd0);
    miso_zero = 1'b1;
  endtask

  initial begin
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    #2;
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_flag", 32'(dut.rd_addr_flag_q), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: write address
    send_bits(10'h0A5, 10, 1'b1);
    step(); step();
    end_txn();

    // 2: write data
    send_bits(10'h13C, 10, 1'b1);
    step();
    end_txn();
    chk("flag_after_write", 32'(dut.rd_addr_flag_q), 32'd0);

    // 3: read address then read data, shift out C3
    send_bits(10'h207, 10, 1'b1);
    end_txn();
    chk("flag_after_rd_addr", 32'(dut.rd_addr_flag_q), 32'd1);
    send_bits(10'h3AA, 10, 1'b1);
    chk("flag_after_rd_data", 32'(dut.rd_addr_flag_q), 32'd0);
    step(); step();
    tx_data = 8'hC3; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check_shift("miso_c3", 8'hC3);
    tx_data = 8'hFF; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    end_txn();

    // 4: abort after 5 bits, then a full frame
    send_bits(10'h155, 5, 1'b0);
    end_txn();
    chk("rx_data_hold_abort", 32'(rx_data), 32'h3AA);
    send_bits(10'h0FF, 10, 1'b1);
    end_txn();

    // 5: async reset mid shift-out
    send_bits(10'h2F0, 10, 1'b1);
    end_txn();
    send_bits(10'h355, 10, 1'b1);
    step();
    tx_data = 8'hA5; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    miso_zero = 1'b0;
    step(); chk("miso_a5_b7", 32'(MISO), 32'd1);
    step(); chk("miso_a5_b6", 32'(MISO), 32'd0);
    step(); chk("miso_a5_b5", 32'(MISO), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_flag", 32'(dut.rd_addr_flag_q), 32'd0);
    SS_n = 1'b1;
    miso_zero = 1'b1;
    step();
    rst = 1'b0;
    step();
    send_bits(10'h2C3, 10, 1'b1);
    chk("post_rst_rd_addr_flag", 32'(dut.rd_addr_flag_q), 32'd1);
    tx_data = 8'hFF; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    end_txn();

    // 6: early tx_valid during the READ_DATA receive phase is ignored
    tx_data = 8'h81; tx_valid = 1'b1;
    send_bits(10'h3FF, 10, 1'b1);
    tx_valid = 1'b0;
    step(); step(); step();
    tx_data = 8'h3C; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check_shift("miso_3c", 8'h3C);
    end_txn();

    step(); step();
    chk("scoreboard_empty", 32'(exp_rx.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
